// File: rtl/elevator_car_if.sv
// Call/decision/status bundle between the car controller and the direction
// calculator side (slave = car controller).
interface elevator_car_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] call_req;
    logic                  direction;
    logic                  should_move;
    logic [NUM_FLOORS-1:0] floors_called;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  moving;
    logic                  move_up;
    logic                  door_open;
    logic                  arrived;

    modport slave (
        input  call_req, direction, should_move,
        output floors_called, current_floor, moving, move_up, door_open, arrived
    );

    modport master (
        output call_req, direction, should_move,
        input  floors_called, current_floor, moving, move_up, door_open, arrived
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: latches floor calls, times travel and door dwell.
// Optional DOOR_HOLD_EN: a same-floor call during DOOR re-extends the dwell.
module elevator_car_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic           clk,
    input  logic           reset,
    elevator_car_if.slave  bus
);
    localparam int TMAX  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

    state_e                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [NUM_FLOORS-1:0] called_q, called_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  move_up_q, move_up_d;
    logic                  moving_q, door_q, arrived_q, arrived_d;

    logic [NUM_FLOORS-1:0] cur_oh, set_mask, clr_mask;
    logic                  at_top, at_bot, here_called, legal_move;
`ifdef DOOR_HOLD_EN
    logic                  hold_req;
`endif

    always_comb begin
        cur_oh      = NUM_FLOORS'(1) << floor_q;
        at_top      = (floor_q == FLOOR_W'(NUM_FLOORS - 1));
        at_bot      = (floor_q == '0);
        here_called = |(called_q & cur_oh);
        legal_move  = bus.should_move && (bus.direction ? !at_top : !at_bot);
`ifdef DOOR_HOLD_EN
        hold_req    = |(bus.call_req & cur_oh);
`endif
        state_d   = state_q;
        timer_d   = timer_q;
        floor_d   = floor_q;
        move_up_d = move_up_q;
        arrived_d = 1'b0;
        set_mask  = bus.call_req;
        clr_mask  = '0;

        case (state_q)
            IDLE: begin
                if (here_called) begin
                    state_d   = DOOR;
                    clr_mask  = cur_oh;
                    arrived_d = 1'b1;
                    timer_d   = TMR_W'(DOOR_CYCLES);
                end else if (legal_move) begin
                    state_d   = MOVE;
                    move_up_d = bus.direction;
                    timer_d   = TMR_W'(TRAVEL_CYCLES);
                end
            end
            MOVE: begin
                // Floor step lands on the same edge that returns to IDLE.
                if (timer_q <= TMR_W'(1)) begin
                    timer_d = '0;
                    floor_d = move_up_q ? floor_q + 1'b1 : floor_q - 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DOOR: begin
                // Door already open here, so a same-floor call is not latched.
                set_mask = bus.call_req & ~cur_oh;
`ifdef DOOR_HOLD_EN
                if (hold_req) begin
                    timer_d = TMR_W'(DOOR_CYCLES);
                end else
`endif
                if (timer_q <= TMR_W'(1)) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        called_d = (called_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            called_q  <= '0;
            floor_q   <= '0;
            move_up_q <= 1'b0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            called_q  <= called_d;
            floor_q   <= floor_d;
            move_up_q <= move_up_d;
            moving_q  <= (state_d == MOVE);
            door_q    <= (state_d == DOOR);
            arrived_q <= arrived_d;
        end
    end

    assign bus.floors_called = called_q;
    assign bus.current_floor = floor_q;
    assign bus.moving        = moving_q;
    assign bus.move_up       = move_up_q;
    assign bus.door_open     = door_q;
    assign bus.arrived       = arrived_q;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Self-checking bench for elevator_car_ctrl: arrival scoreboard plus timing checks.
module tb_elevator_car_ctrl;
    localparam int NF = 8;
    localparam int FW = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_run = 0;
    int   n_fail = 0;
    int   exp_q[$];

    logic use_model, man_dir, man_sm, m_dir, m_sm;

    elevator_car_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_car_ctrl #(.NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Direction calculator model: keep heading up while any higher call is pending.
    always_comb begin
        m_dir = 1'b0;
        m_sm  = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (bus.floors_called[f] && f > int'(bus.current_floor)) begin
                m_dir = 1'b1;
                m_sm  = 1'b1;
            end
            if (bus.floors_called[f] && f < int'(bus.current_floor)) m_sm = 1'b1;
        end
    end

    assign bus.direction   = use_model ? m_dir : man_dir;
    assign bus.should_move = use_model ? m_sm  : man_sm;

    task automatic chk(input string tag, input int obs, input int exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_call(input logic [NF-1:0] v);
        bus.call_req = v;
        tick(1);
        bus.call_req = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    function automatic int bit_at(input int f);
        return int'(bus.floors_called[f]);
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(bus.floors_called == '0 && !bus.moving && !bus.door_open) && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", int'(bus.floors_called == '0 && !bus.moving && !bus.door_open), 1);
    endtask

    task automatic wait_moving(input int budget);
        int n = 0;
        while (!bus.moving && n < budget) begin
            tick(1);
            n++;
        end
        chk("move_timeout", int'(bus.moving), 1);
    endtask

    task automatic wait_door(input int budget);
        int n = 0;
        while (!bus.door_open && n < budget) begin
            tick(1);
            n++;
        end
        chk("door_timeout", int'(bus.door_open), 1);
    endtask

    // Counts door_open cycles starting from a sample where the door is open.
    task automatic measure_door(output int cnt);
        cnt = 0;
        while (bus.door_open && cnt < 40) begin
            cnt++;
            tick(1);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.arrived) begin
            if (exp_q.size() == 0) begin
                chk("arrive_unexpected", 1, 0);
            end else begin
                automatic int e = exp_q.pop_front();
                chk("arrive_floor", int'(bus.current_floor), e);
                chk("arrive_cleared", bit_at(int'(bus.current_floor)), 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, k, last, prev, mv, expd;
        bus.call_req = '0;
        use_model = 1'b1;
        man_dir = 1'b0;
        man_sm = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("rst_called", int'(bus.floors_called), 0);
        chk("rst_floor", int'(bus.current_floor), 0);
        chk("rst_moving", int'(bus.moving), 0);
        chk("rst_move_up", int'(bus.move_up), 0);
        chk("rst_door", int'(bus.door_open), 0);
        chk("rst_arrived", int'(bus.arrived), 0);

        // Reset mid-MOVE from floor 2 to 3
        exp_q.push_back(2);
        pulse_call(8'h04);
        wait_idle(100);
        chk("t1_at2", int'(bus.current_floor), 2);
        pulse_call(8'h08);
        wait_moving(10);
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("t1_floor", int'(bus.current_floor), 0);
        chk("t1_called", int'(bus.floors_called), 0);
        chk("t1_moving", int'(bus.moving), 0);
        chk("t1_door", int'(bus.door_open), 0);
        tick(1);
        chk("t1_still_idle", int'(bus.moving), 0);

        // Call at current floor opens the door
        exp_q.push_back(0);
        pulse_call(8'h01);
        chk("t2_latched", int'(bus.floors_called), 1);
        tick(1);
        chk("t2_arrived", int'(bus.arrived), 1);
        chk("t2_door", int'(bus.door_open), 1);
        chk("t2_cleared", int'(bus.floors_called), 0);
        measure_door(cnt);
        chk("t2_door_len", cnt, 6);
        chk("t2_idle", int'(bus.moving), 0);

        // Travel 0 -> 3, 5 cycles per step
        exp_q.push_back(3);
        pulse_call(8'h08);
        k = 0; last = 0; prev = 0;
        while (!bus.door_open && k < 60) begin
            tick(1);
            k++;
            if (int'(bus.current_floor) != prev) begin
                chk("t3_step_floor", int'(bus.current_floor), prev + 1);
                chk("t3_step_time", k - last, 5);
                last = k;
                prev = int'(bus.current_floor);
            end
        end
        chk("t3_door", int'(bus.door_open), 1);
        chk("t3_floor", int'(bus.current_floor), 3);
        measure_door(cnt);
        chk("t3_door_len", cnt, 6);
        chk("t3_called", int'(bus.floors_called), 0);

        // Illegal direction requests at the end floors
        do_reset();
        use_model = 1'b0; man_sm = 1'b1; man_dir = 1'b0;
        mv = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            mv += int'(bus.moving);
        end
        chk("t4_bot_moving", mv, 0);
        chk("t4_bot_floor", int'(bus.current_floor), 0);
        use_model = 1'b1;
        exp_q.push_back(7);
        pulse_call(8'h80);
        wait_idle(120);
        chk("t4_at7", int'(bus.current_floor), 7);
        use_model = 1'b0; man_sm = 1'b1; man_dir = 1'b1;
        mv = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            mv += int'(bus.moving);
        end
        chk("t4_top_moving", mv, 0);
        chk("t4_top_floor", int'(bus.current_floor), 7);
        use_model = 1'b1; man_sm = 1'b0;

        // Calls latched during MOVE; clear beats set at DOOR entry
        do_reset();
        exp_q.push_back(1);
        exp_q.push_back(7);
        pulse_call(8'h02);
        wait_moving(10);
        pulse_call(8'h80);
        chk("t5_bit7_latched", bit_at(7), 1);
        k = 0;
        while (bus.current_floor != 3'd1 && k < 20) begin
            tick(1);
            k++;
        end
        chk("t5_at1", int'(bus.current_floor), 1);
        chk("t5_bit7_kept", bit_at(7), 1);
        bus.call_req = 8'h02;
        tick(1);
        bus.call_req = '0;
        chk("t5_arrived", int'(bus.arrived), 1);
        chk("t5_bit1_clear", bit_at(1), 0);
        chk("t5_bit7_still", bit_at(7), 1);
        wait_idle(150);
        chk("t5_end_floor", int'(bus.current_floor), 7);

        // Same-floor call on door cycle 4
        do_reset();
        exp_q.push_back(2);
        pulse_call(8'h04);
        wait_door(30);
        tick(3);
        cnt = 4;
        bus.call_req = 8'h04;
        tick(1);
        bus.call_req = '0;
        chk("t6_not_latched", bit_at(2), 0);
        while (bus.door_open && cnt < 40) begin
            cnt++;
            tick(1);
        end
`ifdef DOOR_HOLD_EN
        expd = 10;
`else
        expd = 6;
`endif
        chk("t6_door_len", cnt, expd);
        chk("t6_bit2", bit_at(2), 0);
        tick(3);
        chk("t6_no_reopen", int'(bus.door_open), 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
